fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the program counter register and feeding its next-value input. Takes the current PC, issues a req/ack read to instruction memory, and latches the returned byte into an instruction register. Presents the instruction to the decoder with a valid/ready handshake. Drives pc_next every cycle, because the PC register loads unconditionally on every clock edge.

Parameters:
DATA_W, 8, instruction and PC width in bits.
TIMEOUT_CYCLES, 15, FETCH cycles without ack before abort (only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
pc_in  in  DATA_W  current PC register output
pc_next  out  DATA_W  value the PC register loads next edge (combinational)
imem_req  out  1  instruction memory read request
imem_addr  out  DATA_W  read address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  DATA_W  read data
instr  out  DATA_W  instruction register
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  decoder accepts instr
branch_taken  in  1  redirect; sampled only on the valid&ready handshake cycle
branch_target  in  DATA_W  redirect address
fetch_err  out  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset: clk, reset synchronous active-high. On reset: state=IDLE, instr=0x00, instr_valid=0, imem_req=0, fetch_err=0. pc_next=0x00 while reset is high.
- Reset mid-operation overrides everything. Any outstanding request is abandoned. An ack arriving after reset is ignored.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: pc_next=pc_in. Unconditionally moves to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc_in; both held stable until ack.
  - pc_next=pc_in while there is no ack.
  - On the imem_ack cycle: instr<=imem_rdata, instr_valid<=1, pc_next=pc_in+1 modulo 2^DATA_W (0xFF wraps to 0x00), state->HOLD.
  - Latency from FETCH entry to instr_valid is the memory ack delay + 1 edge; a zero-wait memory gives 1 cycle.
- HOLD:
  - imem_req=0; instr and instr_valid held stable.
  - Without a handshake: pc_next=pc_in.
  - On the instr_valid&instr_ready cycle: pc_next=branch_target if branch_taken, else pc_in. Then instr_valid<=0 and state->FETCH.
  - Steady-state throughput with zero-wait memory and ready held high: one instruction per 2 cycles.
- imem_ack is ignored outside FETCH.
- branch_taken is ignored outside the handshake cycle.
- instr_ready is ignored while instr_valid=0.
- Simultaneous events: ack and reset on the same edge, reset wins. Branch and reset on the same edge, reset wins.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: imem_req drops, instr<=0x00 (NOP), instr_valid<=1, fetch_err pulses for 1 cycle, pc_next=pc_in+1, state->HOLD.
  - An ack on the same cycle as the timeout takes priority over the timeout.
- Undefined: no counter; fetch_err is tied to 0; FETCH waits indefinitely.

Decomposition:
- Shared package aardvark_pkg:
  - fetch state enum (IDLE/FETCH/HOLD)
  - NOP_OPCODE=8'h00
  - default DATA_W
- One sub-module is natural: fetch_watchdog (the timeout counter, present only with FETCH_TIMEOUT_EN).
- Next-PC mux and increment stay inline.

Test Plan:
- Reset held 2 cycles, pc_in=0x00, release, zero-wait mem returns 0x3C -> imem_req=1 with addr 0x00; next edge instr=0x3C, instr_valid=1; pc_next=0x01 on the ack cycle.
- Mem ack delayed 4 cycles -> imem_addr and imem_req stable all 4 cycles, pc_next=pc_in throughout; instr_valid asserts the edge after ack.
- instr_ready low for 3 cycles in HOLD -> instr stable, pc_next=pc_in; ready high -> valid drops next edge, new FETCH begins.
- pc_in=0xFF fetch -> pc_next=0x00. Handshake with branch_taken=1, target=0x80 -> pc_next=0x80 that cycle, next imem_addr=0x80.
- Reset asserted during FETCH with ack arriving the following cycle -> instr_valid=0, instr=0x00, ack ignored, state IDLE.
- FETCH_TIMEOUT_EN, no ack -> after 15 FETCH cycles imem_req=0, instr=0x00, instr_valid=1, fetch_err=1 for 1 cycle.

Source files
------------

// File: rtl/aardvark_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t  : FSM encoding of the fetch stage (IDLE/FETCH/HOLD)
//   NOP_OPCODE     : instruction substituted when a fetch is aborted
//   DEFAULT_DATA_W : default instruction/PC width
package aardvark_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch timeout counter. Counts consecutive FETCH cycles without an ack and
// flags the cycle on which the limit is reached.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   active     : fetch stage is in FETCH this cycle
//   ack        : memory ack this cycle (restarts the count)
//   expired    : this FETCH cycle is the TIMEOUT_CYCLES-th without ack
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of earlier ack-less cycles of the current FETCH,
    // so the limit is hit when it equals TIMEOUT_CYCLES-1 in a new ack-less cycle.
    assign expired = active && !ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Clearing whenever not in FETCH guarantees a zero count on FETCH entry.
    always_ff @(posedge clk) begin
        if (reset || !active || ack) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage between the PC register and the decoder.
// Issues a req/ack read at the current PC, latches the returned instruction
// and offers it to the decoder with valid/ready. pc_next is driven every
// cycle since the PC register loads on every edge.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pc_in / pc_next     : PC register output / value it loads next edge
//   imem_req/addr/ack/rdata : instruction memory read interface
//   instr, instr_valid, instr_ready : decoder handshake
//   branch_taken, branch_target     : redirect, sampled on handshake only
//   fetch_err           : one-cycle pulse when a fetch times out
// Optional feature macro: FETCH_TIMEOUT_EN (abort a fetch after
// TIMEOUT_CYCLES ack-less cycles and deliver a NOP).
module fetch_unit
    import aardvark_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_next,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              fetch_err
);

    fetch_state_t state;
    logic         handshake;
    logic         timeout;

    assign handshake = (state == HOLD) && instr_valid && instr_ready;

    // pc_next echoes pc_in while a fetch is pending, so the address stays stable.
    assign imem_addr = pc_in;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (state == FETCH),
        .ack    (imem_ack),
        .expired(timeout)
    );
`else
    // Without the watchdog a fetch waits forever; the limit is not used.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    // Next-PC mux: advance on fetch completion (ack or abort), redirect only
    // on a handshake with a taken branch, otherwise hold.
    always_comb begin
        pc_next = pc_in;
        if (reset) begin
            pc_next = '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack || timeout) begin
                        pc_next = pc_in + DATA_W'(1);
                    end
                end
                HOLD: begin
                    if (handshake && branch_taken) begin
                        pc_next = branch_target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= DATA_W'(NOP_OPCODE);
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    // An ack on the timeout cycle wins over the abort.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else if (timeout) begin
                        instr       <= DATA_W'(NOP_OPCODE);
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        fetch_err   <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
